// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel synchroniser, optional debounce (MULTI_EDGE_FILTER_EN),
// registered edge pulses selected by rise/fall enables, and sticky event flags.
module multi_edge_detector #(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_in,
    input  logic [WIDTH-1:0] i_rise_en,
    input  logic [WIDTH-1:0] i_fall_en,
    input  logic [WIDTH-1:0] i_evt_clr,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_pulse,
    output logic [WIDTH-1:0] o_evt,
    output logic             o_any_evt
);
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_set;

    if (WIDTH < 1 || SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_param
        $error("multi_edge_detector: illegal parameter value");
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= i_in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

`ifdef MULTI_EDGE_FILTER_EN
    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
    logic [CW-1:0] r_cnt [WIDTH];
    // A new level is accepted on the FILTER_CYCLES-th consecutive differing sample.
    for (genvar i = 0; i < WIDTH; i++) begin : g_filt
        assign w_accept[i] = (w_s[i] != o_level[i]) && (r_cnt[i] == LAST);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_cnt[i] <= '0;
            else
                r_cnt[i] <= (w_s[i] == o_level[i] || w_accept[i]) ? '0 : r_cnt[i] + 1'b1;
        end
    end
`else
    assign w_accept = w_s ^ o_level;
`endif

    // On an accepted change the new level equals w_s.
    assign w_set = w_accept & ((w_s & i_rise_en) | (~w_s & i_fall_en));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_level <= '0;
            o_pulse <= '0;
            o_evt   <= '0;
        end else begin
            o_level <= o_level ^ w_accept;
            o_pulse <= w_set;
            o_evt   <= w_set | (o_evt & ~i_evt_clr);
        end
    end

    assign o_any_evt = |o_evt;
endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: scoreboarded random and directed checks against a window-based
// reference model of the edge detector.
module tb_multi_edge_detector;
    localparam int W  = 4;
    localparam int SS = 2;
    localparam int FC = 3;
`ifdef MULTI_EDGE_FILTER_EN
    localparam int FE = FC;
`else
    localparam int FE = 1;
`endif
    localparam int LAT = SS + FE;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] in_r = '0, rise = '0, fall = '0, clr = '0;
    logic [W-1:0] o_level, o_pulse, o_evt;
    logic         o_any_evt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3*W-1:0] exp_q[$];
    logic [W-1:0]   in_hist[$];
    logic [W-1:0]   win[$];
    logic [W-1:0]   m_lvl = '0, m_pulse = '0, m_evt = '0;
    logic [3*W-1:0] mon_e;

    multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .i_in(in_r), .i_rise_en(rise), .i_fall_en(fall),
        .i_evt_clr(clr), .o_level(o_level), .o_pulse(o_pulse), .o_evt(o_evt),
        .o_any_evt(o_any_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_hist.delete();
        win.delete();
        m_lvl = '0;
        m_pulse = '0;
        m_evt = '0;
    endtask

    // Level flips once the last FE filter samples all differ from it.
    task automatic model_edge(input logic [W-1:0] cur, input logic [W-1:0] r,
                              input logic [W-1:0] f, input logic [W-1:0] c);
        logic [W-1:0] s_used, acc;
        s_used = (in_hist.size() >= SS) ? in_hist[in_hist.size()-SS] : '0;
        in_hist.push_back(cur);
        if (in_hist.size() > SS) void'(in_hist.pop_front());
        win.push_back(s_used);
        if (win.size() > FE) void'(win.pop_front());
        acc = '0;
        if (win.size() == FE) begin
            acc = '1;
            foreach (win[j]) acc &= win[j] ^ m_lvl;
        end
        m_lvl   = m_lvl ^ acc;
        m_pulse = acc & ((m_lvl & r) | (~m_lvl & f));
        m_evt   = m_pulse | (m_evt & ~c);
        exp_q.push_back({m_lvl, m_pulse, m_evt});
    endtask

    task automatic step(input logic [W-1:0] i, input logic [W-1:0] r,
                        input logic [W-1:0] f, input logic [W-1:0] c);
        rst_n = 1'b1;
        in_r = i;
        rise = r;
        fall = f;
        clr = c;
        model_edge(i, r, f, c);
        @(posedge clk);
        #2;
    endtask

    task automatic rst_step(input logic [W-1:0] i);
        rst_n = 1'b0;
        in_r = i;
        model_reset();
        exp_q.push_back('0);
        #1;
        chk("async_rst_level", o_level, '0);
        chk("async_rst_pulse", o_pulse, '0);
        chk("async_rst_evt", o_evt, '0);
        chk("async_rst_any", {3'b0, o_any_evt}, '0);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("level", o_level, mon_e[3*W-1:2*W]);
            chk("pulse", o_pulse, mon_e[2*W-1:W]);
            chk("evt", o_evt, mon_e[W-1:0]);
            chk("any_evt", {3'b0, o_any_evt}, {3'b0, |mon_e[W-1:0]});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        logic [W-1:0] seen, r_in;
        rst_step('0);
        rst_step('0);
        // single channel rise then fall with both enables
        for (int k = 0; k < LAT; k++) step(4'h1, 4'h1, 4'h1, 4'h0);
        chk("t1_rise_pulse", o_pulse & 4'h1, 4'h1);
        chk("t1_rise_level", o_level & 4'h1, 4'h1);
        step(4'h1, 4'h1, 4'h1, 4'h0);
        chk("t1_pulse_one_cycle", o_pulse & 4'h1, 4'h0);
        chk("t1_evt", o_evt & 4'h1, 4'h1);
        chk("t1_any", {3'b0, o_any_evt}, 4'h1);
        for (int k = 0; k < LAT; k++) step(4'h0, 4'h1, 4'h1, 4'h0);
        chk("t1_fall_pulse", o_pulse & 4'h1, 4'h1);
        chk("t1_fall_level", o_level & 4'h1, 4'h0);
        // short glitch on channel 1
        rst_step('0);
        seen = '0;
        for (int k = 0; k < 12; k++) begin
            step((k < 2) ? 4'h2 : 4'h0, 4'h2, 4'h2, 4'h0);
            seen |= o_level | o_pulse | o_evt;
        end
`ifdef MULTI_EDGE_FILTER_EN
        chk("t2_glitch_suppressed", seen & 4'h2, 4'h0);
`endif
        // rise-only reporting on channel 2
        rst_step('0);
        pc = 0;
        seen = '0;
        for (int k = 0; k < 20; k++) begin
            step((k < 10) ? 4'h4 : 4'h0, 4'h4, 4'h0, 4'h0);
            pc += int'(o_pulse[2]);
            seen |= o_level;
        end
        chk("t3_pulse_count", 4'(pc), 4'h1);
        chk("t3_level_rose", seen & 4'h4, 4'h4);
        chk("t3_level_fell", o_level & 4'h4, 4'h0);
        // set wins over clear on channel 3
        rst_step('0);
        for (int k = 0; k < LAT; k++) step(4'h8, 4'h8, 4'h8, 4'h0);
        chk("t4_evt_set", o_evt & 4'h8, 4'h8);
        for (int k = 0; k < LAT - 1; k++) step(4'h0, 4'h8, 4'h8, 4'h0);
        step(4'h0, 4'h8, 4'h8, 4'h8);
        chk("t4_pulse_with_clr", o_pulse & 4'h8, 4'h8);
        chk("t4_set_wins", o_evt & 4'h8, 4'h8);
        step(4'h0, 4'h8, 4'h8, 4'h8);
        chk("t4_clr", o_evt & 4'h8, 4'h0);
        chk("t4_any_clr", {3'b0, o_any_evt}, 4'h0);
        // input high at reset release, then reset mid-count
        rst_step(4'hF);
        for (int k = 0; k < LAT; k++) step(4'hF, 4'hF, 4'h0, 4'h0);
        chk("t5_release_pulse", o_pulse, 4'hF);
        step(4'h0, 4'hF, 4'h0, 4'h0);
        step(4'h0, 4'hF, 4'h0, 4'h0);
        rst_step(4'h0);
        pc = 0;
        for (int k = 0; k < 10; k++) begin
            step(4'h0, 4'hF, 4'h0, 4'h0);
            pc += int'(|o_pulse);
        end
        chk("t5_no_pulse_after_rst", 4'(pc), 4'h0);
`ifndef MULTI_EDGE_FILTER_EN
        // unfiltered build passes a one-cycle pulse
        rst_step('0);
        step(4'h1, 4'h1, 4'h0, 4'h0);
        step(4'h0, 4'h1, 4'h0, 4'h0);
        step(4'h0, 4'h1, 4'h0, 4'h0);
        chk("t6_pulse_edge3", o_pulse & 4'h1, 4'h1);
        chk("t6_level_edge3", o_level & 4'h1, 4'h1);
        step(4'h0, 4'h1, 4'h0, 4'h0);
        chk("t6_level_edge4", o_level & 4'h1, 4'h0);
`endif
        // randomized traffic with occasional resets
        rst_step('0);
        r_in = '0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_step(r_in);
            end else begin
                for (int b = 0; b < W; b++)
                    if ($urandom_range(0, 99) < 12) r_in[b] = ~r_in[b];
                step(r_in, 4'($urandom), 4'($urandom),
                     ($urandom_range(0, 99) < 15) ? 4'($urandom) : 4'h0);
            end
        end
        step(r_in, 4'h0, 4'h0, 4'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised, multi-channel edge detector: synchronises `WIDTH` asynchronous inputs, optionally debounces each one, and emits per-channel single-cycle pulses on rising, falling or both edges as selected per channel. It also holds sticky per-channel event flags until software clears them. Sits between raw board I/O (buttons, switches, external strobes) and control logic; replaces single-channel hand-built edge FSMs.

## Interface

Parameters:
- `WIDTH`, 4: number of independent channels, ≥1.
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2.
- `FILTER_CYCLES`, 3: consecutive samples a new level must persist before it is accepted, ≥1. Used only with `MULTI_EDGE_FILTER_EN`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in` in WIDTH: raw asynchronous inputs.
- `rise_en` in WIDTH: per channel, report 0→1 transitions.
- `fall_en` in WIDTH: per channel, report 1→0 transitions.
- `evt_clr` in WIDTH: per-channel sticky-flag clear, synchronous.
- `level` out WIDTH: accepted (synchronised, filtered) level.
- `pulse` out WIDTH: one-cycle edge pulse, registered.
- `evt` out WIDTH: sticky event flags.
- `any_evt` out 1: OR of `evt`, combinational from `evt`.

## Operation

- **Reset.** `rst_n` low immediately clears all synchroniser flops, filter counters, `level`, `pulse` and `evt` to 0. `any_evt` therefore reads 0.
- **Synchroniser.** Each channel has a `SYNC_STAGES`-deep flop chain. Call the last stage `s[i]`.
- **Filter.** Each channel has a counter of width `$clog2(FILTER_CYCLES)` (minimum 1).
  - If `s[i]==level[i]`, the counter clears to 0.
  - If `s[i]!=level[i]` and the counter is below `FILTER_CYCLES-1`, the counter increments.
  - If `s[i]!=level[i]` and the counter equals `FILTER_CYCLES-1`, `level[i]` takes `s[i]` and the counter clears.
  - Any return of `s[i]` to `level[i]` before acceptance discards the partial count, so glitches shorter than `FILTER_CYCLES` samples are suppressed.
- **Edge pulse.** On the edge where `level[i]` changes:
  - `pulse[i]` is set to `(new level & rise_en[i]) | (~new level & fall_en[i])`.
  - On every other edge, `pulse[i]` is set to 0.
  - `rise_en`/`fall_en` are sampled only on the edge where `level[i]` changes, and are not registered. If both are 0, `level` still tracks the input but no pulse is produced.
- **Sticky flag.** `evt[i]` is set by the same condition that sets `pulse[i]`, and cleared by `evt_clr[i]`. If set and clear occur on the same edge, set wins, so no event is lost.
- **Channel independence.** Channels are fully independent; simultaneous edges on several channels each produce their own pulse.
- **Reset release.** If an input is already high when reset is released, it is treated as a rising edge (`level` reset value is 0) and produces a pulse if `rise_en` is set.

## Timing

- **Latency.** An input change that is stable before clock edge 1 and held thereafter:
  - reaches `s` on edge `SYNC_STAGES`;
  - is accepted into `level` on edge `SYNC_STAGES+FILTER_CYCLES`;
  - `pulse` is high for exactly the one cycle following that edge.
- **Minimum spacing.** Back-to-back accepted edges on one channel are at least `FILTER_CYCLES` cycles apart, so pulses never merge.
- **`evt` and `any_evt`.** `evt` rises on the same edge as `pulse`. `any_evt` follows `evt` in the same cycle.
- **`evt_clr`.** Takes effect on the next edge.
- **Reset mid-operation.** An asynchronous assert clears every output within the reset-to-Q delay; no pulse is produced by the reset itself.

## Configuration

- **`MULTI_EDGE_FILTER_EN` defined:** the filter counters are implemented as described above.
- **`MULTI_EDGE_FILTER_EN` undefined:**
  - Counters are removed and `level[i]` takes `s[i]` on every edge.
  - Behaviour is identical to `FILTER_CYCLES=1`, and the `FILTER_CYCLES` value is ignored.
  - Latency is `SYNC_STAGES+1` edges.

## Test plan

All scenarios use WIDTH=4, SYNC_STAGES=2, FILTER_CYCLES=3 and `MULTI_EDGE_FILTER_EN` defined unless stated.

1. `rise_en=4'h1`, `fall_en=4'h1`; drive `in[0]` 0→1 before edge 1 and hold → `level[0]`=1 and `pulse[0]`=1 after edge 5, `pulse[0]`=0 after edge 6, `evt[0]`=1, `any_evt`=1. Then drive 1→0 → a second one-cycle pulse 5 edges later.
2. `in[1]` high for only 2 cycles, then low → `level[1]`, `pulse[1]` and `evt[1]` stay 0 throughout.
3. `rise_en=4'h4`, `fall_en=4'h0`; toggle `in[2]` 0→1→0 with 10-cycle holds → exactly one pulse (on the rise). `level[2]` follows both transitions.
4. `evt[3]` already set; assert `evt_clr[3]` on the same edge a new `pulse[3]` fires → `evt[3]` remains 1. Assert `evt_clr[3]` alone → `evt[3]`=0 and `any_evt`=0 next cycle.
5. Hold `in=4'hF` with `rise_en=4'hF`; deassert `rst_n` → `pulse=4'hF` for one cycle after edge 5 post-release. Assert `rst_n` mid-count → all outputs 0 immediately, and no pulse appears after release while `in=0`.
6. Build without `MULTI_EDGE_FILTER_EN`; drive a 1-cycle high on `in[0]` → `level[0]` high for 1 cycle, and `pulse[0]` fires at edge 3 (`rise_en=1`).
